resultado_display: RTL and testbench



---
 rtl/resultado_display.sv | 157 +++++++++++++++
 tb/tb_resultado_display.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/resultado_display.sv
// Result display: latches sign/magnitude, converts to BCD with a double-dabble FSM,
// and scans sign/tens/units onto a common-anode 7-segment display. Option: BLANK_ZERO_EN.
module resultado_display #(
    parameter int unsigned REFRESH_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       sinal,
    input  logic [4:0] magnitude,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_UPDATE  = 2'd2;

    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [1:0]             state_q, state_d;
    logic                   sinal_q, sinal_d;
    logic [4:0]             mag_q, mag_d;
    logic [7:0]             bcd_q, bcd_d;
    logic [7:0]             bcd_adj;
    logic [2:0]             iter_q, iter_d;
    logic                   sign_disp_q, sign_disp_d;
    logic [3:0]             tens_disp_q, tens_disp_d;
    logic [3:0]             units_disp_q, units_disp_d;
    logic [REFRESH_DIV-1:0] cnt_q, cnt_d;
    logic [1:0]             sel;
    logic [6:0]             seg_q, seg_d;
    logic [3:0]             an_q, an_d;

    function automatic logic [6:0] digit_seg(input logic [3:0] v);
        case (v)
            4'd0:    digit_seg = 7'b1000000;
            4'd1:    digit_seg = 7'b1111001;
            4'd2:    digit_seg = 7'b0100100;
            4'd3:    digit_seg = 7'b0110000;
            4'd4:    digit_seg = 7'b0011001;
            4'd5:    digit_seg = 7'b0010010;
            4'd6:    digit_seg = 7'b0000010;
            4'd7:    digit_seg = 7'b1111000;
            4'd8:    digit_seg = 7'b0000000;
            4'd9:    digit_seg = 7'b0010000;
            default: digit_seg = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        sinal_d      = sinal_q;
        mag_d        = mag_q;
        bcd_d        = bcd_q;
        bcd_adj      = bcd_q;
        iter_d       = iter_q;
        sign_disp_d  = sign_disp_q;
        tens_disp_d  = tens_disp_q;
        units_disp_d = units_disp_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    sinal_d = sinal;
                    mag_d   = magnitude;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (bcd_adj[3:0] >= 4'd5) bcd_adj[3:0] = bcd_adj[3:0] + 4'd3;
                if (bcd_adj[7:4] >= 4'd5) bcd_adj[7:4] = bcd_adj[7:4] + 4'd3;
                // MSB-first: iteration i brings in magnitude bit 4-i
                bcd_d  = 8'({bcd_adj, mag_q[3'd4 - iter_q]});
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd4) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                tens_disp_d  = bcd_q[7:4];
                units_disp_d = bcd_q[3:0];
                sign_disp_d  = sinal_q & (mag_q != '0);
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel   = cnt_q[REFRESH_DIV-1 -: 2];
        cnt_d = cnt_q + REFRESH_DIV'(1);
        seg_d = SEG_BLANK;
        an_d  = 4'b1111;
        case (sel)
            2'd0: begin
                seg_d = digit_seg(units_disp_q);
                an_d  = 4'b1110;
            end
            2'd1: begin
`ifdef BLANK_ZERO_EN
                if (tens_disp_q != 4'd0) begin
                    seg_d = digit_seg(tens_disp_q);
                    an_d  = 4'b1101;
                end
`else
                seg_d = digit_seg(tens_disp_q);
                an_d  = 4'b1101;
`endif
            end
            2'd2: begin
                seg_d = sign_disp_q ? SEG_MINUS : SEG_BLANK;
                an_d  = 4'b1011;
            end
            default: begin
                seg_d = SEG_BLANK;
                an_d  = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sinal_q      <= 1'b0;
            mag_q        <= '0;
            bcd_q        <= '0;
            iter_q       <= '0;
            sign_disp_q  <= 1'b0;
            tens_disp_q  <= '0;
            units_disp_q <= '0;
            cnt_q        <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= 4'b1111;
        end else begin
            state_q      <= state_d;
            sinal_q      <= sinal_d;
            mag_q        <= mag_d;
            bcd_q        <= bcd_d;
            iter_q       <= iter_d;
            sign_disp_q  <= sign_disp_d;
            tens_disp_q  <= tens_disp_d;
            units_disp_q <= units_disp_d;
            cnt_q        <= cnt_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign busy = (state_q == ST_CONVERT);
    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_resultado_display.sv
// Scoreboard bench for resultado_display (REFRESH_DIV=4); honours BLANK_ZERO_EN.
module tb_resultado_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       sinal = 1'b0;
    logic [4:0] magnitude = '0;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    resultado_display #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .sinal(sinal), .magnitude(magnitude),
        .busy(busy), .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       s;
        logic [3:0] t;
        logic [3:0] u;
    } disp_t;

    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
    logic [6:0] enc_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    disp_t       sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    function automatic disp_t ref_disp(input logic s, input int unsigned m);
        disp_t d;
        d.s = s && (m != 0);
        d.t = 4'(m / 10);
        d.u = 4'(m % 10);
        return d;
    endfunction

    function automatic logic [3:0] an_for(input int unsigned sel, input disp_t d);
        case (sel)
            0: return 4'b1110;
`ifdef BLANK_ZERO_EN
            1: return (d.t == 4'd0) ? 4'b1111 : 4'b1101;
`else
            1: return 4'b1101;
`endif
            2: return 4'b1011;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle-level view of the spec (latency 6, 16-cycle scan).
    int unsigned mcnt = 0;
    int unsigned tleft = 0;
    disp_t       md = '0;
    disp_t       pend = '0;
    logic [3:0]  an_exp = 4'b1111;
    logic        busy_exp = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mcnt = 0;
            tleft = 0;
            md = '0;
            an_exp = 4'b1111;
            busy_exp = 1'b0;
            sb.delete();
            sb.push_back('0);
        end else begin
            an_exp = an_for(mcnt / 4, md);
            mcnt = (mcnt + 1) % 16;
            if (tleft == 1) md = pend;
            if (tleft != 0) tleft--;
            else if (load) begin
                tleft = 6;
                pend = ref_disp(sinal, int'(magnitude));
                sb.push_back(pend);
            end
            busy_exp = (tleft >= 2);
        end
    end

    // Monitor: per-cycle timing checks plus a 16-cycle scan check per popped result.
    int unsigned scan_left = 0;
    disp_t       cur;
    int unsigned nu, nt, ns;
    logic        prev_rst = 1'b1;
    logic        prev_busy = 1'b0;
    logic        trig;

    initial forever begin
        @(negedge clk);
        check("busy", {7'b0, busy}, {7'b0, busy_exp});
        check("an", {4'b0, an}, {4'b0, an_exp});
        check("dp", {7'b0, dp}, 8'd1);
        if (an_exp == 4'b1111) check("seg_off", {1'b0, seg}, {1'b0, BLANK});
        trig = (prev_rst && !rst) || (prev_busy && !busy && !rst);
        prev_rst = rst;
        prev_busy = busy;
        if (rst) begin
            scan_left = 0;
        end else if (trig) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty: output seen with no expected entry at %0t", $time);
            end else begin
                cur = sb.pop_front();
                scan_left = 18;
                nu = 0; nt = 0; ns = 0;
            end
        end else if (scan_left > 0) begin
            scan_left--;
            if (scan_left < 16) begin
                case (an)
                    4'b1110: begin check("units_seg", {1'b0, seg}, {1'b0, enc_tab[cur.u]}); nu++; end
                    4'b1101: begin check("tens_seg", {1'b0, seg}, {1'b0, enc_tab[cur.t]}); nt++; end
                    4'b1011: begin check("sign_seg", {1'b0, seg}, {1'b0, cur.s ? MINUS : BLANK}); ns++; end
                    default: ;
                endcase
            end
            if (scan_left == 0) begin
                check("units_slots", 8'(nu), 8'd4);
`ifdef BLANK_ZERO_EN
                check("tens_slots", 8'(nt), (cur.t == 4'd0) ? 8'd0 : 8'd4);
`else
                check("tens_slots", 8'(nt), 8'd4);
`endif
                check("sign_slots", 8'(ns), 8'd4);
            end
        end
    end

    task automatic pulse_load(input logic s, input logic [4:0] m);
        @(posedge clk); #1;
        load = 1'b1; sinal = s; magnitude = m;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic settle();
        repeat (30) @(posedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        settle();
        pulse_load(1'b0, 5'd13); settle();
        pulse_load(1'b1, 5'd31); settle();
        pulse_load(1'b1, 5'd0);  settle();
        pulse_load(1'b0, 5'd7);
        pulse_load(1'b1, 5'd22); settle();
        pulse_load(1'b0, 5'd25);
        @(posedge clk);
        pulse_rst(); settle();
        pulse_load(1'b0, 5'd9);  settle();
        for (int i = 0; i < 24; i++) begin
            pulse_load(1'($urandom_range(1)), 5'($urandom_range(31)));
            case ($urandom_range(3))
                0: begin
                    repeat ($urandom_range(3)) @(posedge clk);
                    pulse_load(1'($urandom_range(1)), 5'($urandom_range(31)));
                end
                1: begin
                    repeat ($urandom_range(3)) @(posedge clk);
                    pulse_rst();
                end
                default: ;
            endcase
            settle();
        end
        for (int i = 0; i < 100 && (sb.size() != 0 || scan_left != 0); i++) @(posedge clk);
        if (sb.size() != 0 || scan_left != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries pending, scan_left %0d, required 0", sb.size(), scan_left);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
